// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake engine: direction and state encodings,
// the reverse-direction test and the per-direction unit step.
package snake_pkg;

    typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;

    typedef enum logic [2:0] {INIT, IDLE, SCAN, COMMIT, DEAD} state_t;

    typedef struct packed {
        logic signed [1:0] dx;
        logic signed [1:0] dy;
    } delta_t;

    function automatic logic is_reverse(input dir_t a, input dir_t b);
        case (a)
            UP:      return b == DOWN;
            DOWN:    return b == UP;
            LEFT:    return b == RIGHT;
            default: return b == LEFT;
        endcase
    endfunction

    // y grows downward, so UP is a negative y step
    function automatic delta_t step(input dir_t d);
        delta_t r;
        r = '0;
        case (d)
            UP:      r.dy = -2'sd1;
            DOWN:    r.dy = 2'sd1;
            LEFT:    r.dx = -2'sd1;
            default: r.dx = 2'sd1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/snake_body_ram.sv
// Body segment store: one write port plus two independent registered read ports,
// one for the collision scan and one for the renderer.
module snake_body_ram #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wrEn,
    input  logic [AW-1:0]    wrAddr,
    input  logic [WIDTH-1:0] wrData,
    input  logic [AW-1:0]    scanAddr,
    output logic [WIDTH-1:0] scanData,
    input  logic             rdEn,
    input  logic [AW-1:0]    rdAddr,
    output logic [WIDTH-1:0] rdData
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wrEn) mem[wrAddr] <= wrData;
    end

    // Renderer port holds its last value when not enabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scanData <= '0;
            rdData   <= '0;
        end else begin
            scanData <= mem[scanAddr];
            if (rdEn) rdData <= mem[rdAddr];
        end
    end

endmodule

// File: rtl/snake_engine.sv
// Snake game core: head/direction tracking, circular body buffer, food and
// collision detection, one step per accepted tick.
module snake_engine
    import snake_pkg::*;
#(
    parameter int X_BITS   = 4,
    parameter int Y_BITS   = 4,
    parameter int MAX_LEN  = 32,
    parameter int INIT_LEN = 3,
    parameter int WRAP     = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         btnUp,
    input  logic                         btnDown,
    input  logic                         btnLeft,
    input  logic                         btnRight,
    input  logic                         tick,
    input  logic                         start,
    input  logic [X_BITS-1:0]            foodX,
    input  logic [Y_BITS-1:0]            foodY,
    output logic [X_BITS-1:0]            headX,
    output logic [Y_BITS-1:0]            headY,
    output logic [$clog2(MAX_LEN+1)-1:0] length,
    output logic                         ate,
    output logic                         game_over,
    output logic                         busy,
    output logic                         tick_miss,
    input  logic [$clog2(MAX_LEN)-1:0]   rd_idx,
    output logic [X_BITS+Y_BITS-1:0]     rd_pos,
    output logic                         rd_valid
);

    localparam int PW = $clog2(MAX_LEN);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int CW = X_BITS + Y_BITS;
    localparam logic [X_BITS-1:0] X_MID = X_BITS'(2 ** (X_BITS - 1));
    localparam logic [Y_BITS-1:0] Y_MID = Y_BITS'(2 ** (Y_BITS - 1));

    state_t state, stateNext;
    dir_t   dir, pending, reqDir;
    logic   reqValid;

    logic [PW-1:0] headPtr, tailPtr;
    logic [LW-1:0] initCnt, scanCnt;
    logic [X_BITS-1:0] nextX, candX;
    logic [Y_BITS-1:0] nextY, candY;
    logic grow, foodHit, hit, offGrid;
    delta_t delta;

    logic          wrEn, rdEn;
    logic [PW-1:0] wrAddr, scanAddr, rdAddr, curAddr, lastAddr;
    logic [CW-1:0] wrData, scanData;

    always_comb begin
        reqValid = 1'b1;
        reqDir   = RIGHT;
        if (btnUp)         reqDir = UP;
        else if (btnDown)  reqDir = DOWN;
        else if (btnLeft)  reqDir = LEFT;
        else if (btnRight) reqDir = RIGHT;
        else               reqValid = 1'b0;
    end

    // Candidate head from the pending direction; the X_BITS/Y_BITS adders wrap naturally
    always_comb begin
        delta   = step(pending);
        candX   = headX + X_BITS'(signed'(delta.dx));
        candY   = headY + Y_BITS'(signed'(delta.dy));
        hit     = ({candX, candY} == {foodX, foodY});
        offGrid = (WRAP == 0) &&
                  ((pending == LEFT  && headX == '0) || (pending == RIGHT && headX == '1) ||
                   (pending == UP    && headY == '0) || (pending == DOWN  && headY == '1));
    end

    assign curAddr  = headPtr - PW'(scanCnt);
    assign lastAddr = grow ? tailPtr : tailPtr + PW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= INIT;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            INIT:   if (initCnt == LW'(INIT_LEN - 1)) stateNext = IDLE;
            IDLE:   if (tick) stateNext = offGrid ? DEAD : SCAN;
            SCAN: begin
                if (scanData == {nextX, nextY}) stateNext = DEAD;
                else if (curAddr == lastAddr)   stateNext = COMMIT;
            end
            COMMIT: stateNext = IDLE;
            DEAD:   if (start) stateNext = INIT;
            default: stateNext = INIT;
        endcase
    end

    // The scan port is read one index ahead so each SCAN cycle sees its own segment
    always_comb begin
        wrEn     = 1'b0;
        wrAddr   = headPtr + PW'(1);
        wrData   = {nextX, nextY};
        scanAddr = (state == SCAN) ? headPtr - PW'(scanCnt + LW'(1)) : headPtr;
        rdEn     = LW'(rd_idx) < length;
        rdAddr   = headPtr - rd_idx;
        if (state == INIT) begin
            wrEn   = 1'b1;
            wrAddr = PW'(initCnt);
            wrData = {headX - X_BITS'(INIT_LEN - 1) + X_BITS'(initCnt), headY};
        end else if (state == COMMIT) begin
            wrEn = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir       <= RIGHT;
            pending   <= RIGHT;
            headX     <= X_MID;
            headY     <= Y_MID;
            length    <= '0;
            headPtr   <= '0;
            tailPtr   <= '0;
            initCnt   <= '0;
            scanCnt   <= '0;
            nextX     <= '0;
            nextY     <= '0;
            grow      <= 1'b0;
            foodHit   <= 1'b0;
            ate       <= 1'b0;
            tick_miss <= 1'b0;
            busy      <= 1'b0;
            game_over <= 1'b0;
            rd_valid  <= 1'b0;
        end else begin
            ate       <= 1'b0;
            tick_miss <= tick && (state == INIT || state == SCAN || state == COMMIT);
            busy      <= !(stateNext == IDLE || stateNext == DEAD);
            game_over <= (stateNext == DEAD);
            rd_valid  <= rdEn;
            if (state != INIT && reqValid && !is_reverse(reqDir, dir)) pending <= reqDir;
            case (state)
                INIT: begin
                    initCnt <= initCnt + LW'(1);
                    if (initCnt == LW'(INIT_LEN - 1)) begin
                        length  <= LW'(INIT_LEN);
                        headPtr <= PW'(INIT_LEN - 1);
                        tailPtr <= '0;
                    end
                end
                IDLE: if (tick) begin
                    dir     <= pending;
                    nextX   <= candX;
                    nextY   <= candY;
                    foodHit <= hit;
                    grow    <= hit && (length < LW'(MAX_LEN));
                    scanCnt <= '0;
                end
                SCAN: scanCnt <= scanCnt + LW'(1);
                COMMIT: begin
                    headPtr <= headPtr + PW'(1);
                    headX   <= nextX;
                    headY   <= nextY;
                    ate     <= foodHit;
                    if (grow) length  <= length + LW'(1);
                    else      tailPtr <= tailPtr + PW'(1);
                end
                DEAD: if (start) begin
                    dir     <= RIGHT;
                    pending <= RIGHT;
                    headX   <= X_MID;
                    headY   <= Y_MID;
                    length  <= '0;
                    headPtr <= '0;
                    tailPtr <= '0;
                    initCnt <= '0;
                end
                default: ;
            endcase
        end
    end

    snake_body_ram #(.DEPTH(MAX_LEN), .WIDTH(CW), .AW(PW)) bodyRam (
        .clk      (clk),
        .reset    (reset),
        .wrEn     (wrEn),
        .wrAddr   (wrAddr),
        .wrData   (wrData),
        .scanAddr (scanAddr),
        .scanData (scanData),
        .rdEn     (rdEn),
        .rdAddr   (rdAddr),
        .rdData   (rd_pos)
    );

endmodule

// File: doc/snake_engine.md
Name: snake_engine

Overview:
- Parametrised successor to the single-player snake controller.
- Owns the head position, the direction latch and a circular body buffer of grid coordinates; detects food and collisions, and grows the snake.
- Advances one step per external `tick`, e.g. from the game-speed divider.
- Sits between the button debouncers and the renderer/food generator. The renderer reads body segments through an indexed read port.

Parameters:
- X_BITS, 4, width of the x coordinate; grid width is 2**X_BITS.
- Y_BITS, 4, width of the y coordinate; grid height is 2**Y_BITS.
- MAX_LEN, 32, body buffer depth in segments; must be a power of 2 and ≤ 2**(X_BITS+Y_BITS).
- INIT_LEN, 3, segment count after reset or restart; 2 ≤ INIT_LEN ≤ min(MAX_LEN, 2**X_BITS/2).
- WRAP, 1, 1 = edges wrap around (modulo the grid size); 0 = leaving the grid kills the snake.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- btnUp, btnDown, btnLeft, btnRight  in  1 each  debounced direction requests, level sensitive
- tick  in  1  single-cycle step strobe
- start  in  1  restart request; honoured only in DEAD
- foodX  in  X_BITS  food x coordinate
- foodY  in  Y_BITS  food y coordinate
- headX  out  X_BITS  current head x
- headY  out  Y_BITS  current head y
- length  out  $clog2(MAX_LEN+1)  current segment count
- ate  out  1  one-cycle pulse on a food hit
- game_over  out  1  high while in DEAD
- busy  out  1  high in any state other than IDLE or DEAD
- tick_miss  out  1  one-cycle pulse when a tick arrives while busy
- rd_idx  in  $clog2(MAX_LEN)  body index to read; 0 = head
- rd_pos  out  X_BITS+Y_BITS  {x,y} of segment rd_idx, valid one cycle after rd_idx
- rd_valid  out  1  registered flag: rd_idx < length

Behaviour:
- Coordinate convention: x increases rightward, y increases downward, so Up means y-1.
- Reset (async): state=INIT, dir=RIGHT, pending=RIGHT, length=0.
  - All outputs go to 0 except headX=2**X_BITS/2 and headY=2**Y_BITS/2.
- INIT: writes INIT_LEN segments in INIT_LEN cycles.
  - Segment k is at (headX-k, headY).
  - tail_ptr=0, head_ptr=INIT_LEN-1, length=INIT_LEN.
  - Then go to IDLE.
- Direction latch: runs every cycle in every state except INIT.
  - Button priority is Up > Down > Left > Right.
  - The chosen direction loads `pending` unless it is the reverse of `dir`; a reverse request is ignored.
  - `dir` <= `pending` only when a tick is accepted.
- IDLE: on tick, compute next head from `pending` and go to SCAN.
  - If WRAP=0 and the step leaves the grid, go directly to DEAD.
  - If WRAP=1, coordinates wrap modulo the grid size.
  - grow = (next head == {foodX,foodY}) && length < MAX_LEN.
  - Food is sampled in that same cycle.
- SCAN: compares the next head against one body segment per cycle, from the head toward the tail.
  - When not growing, the tail segment is excluded from the comparison.
  - Any match goes to DEAD.
  - Otherwise go to COMMIT after the last segment. SCAN therefore takes length cycles when growing and length-1 otherwise.
- COMMIT: one cycle.
  - head_ptr++ and write the new head there; headX/headY update.
  - If grow: length++ and tail_ptr is unchanged. Otherwise tail_ptr++.
  - ate pulses on any food hit, including at MAX_LEN, where the snake eats without growing.
  - Go to IDLE.
- Tick-to-head latency: SCAN cycles + 2.
- A tick arriving in SCAN, COMMIT or INIT is dropped and pulses tick_miss.
- DEAD: game_over=1, ticks are ignored, buffer contents are frozen and stay readable. start goes to INIT.
- Pointers: mod MAX_LEN. Read address = head_ptr - rd_idx (mod MAX_LEN). rd_pos is registered. An out-of-range rd_idx returns rd_valid=0 and rd_pos holding its previous value.
- Asserting reset in any state, including mid-SCAN, aborts immediately; no partial write survives.

Decomposition:
- Shared package snake_pkg holds:
  - the dir_t encoding (UP, DOWN, LEFT, RIGHT);
  - the state_t encoding (INIT, IDLE, SCAN, COMMIT, DEAD);
  - the is_reverse() and step() helper functions.
- Sub-module snake_body_ram: MAX_LEN x (X_BITS+Y_BITS) simple dual-port RAM, with one write port and two read ports (scan and renderer), registered reads.

Test Plan:
- Reset, then run INIT_LEN+1 idle cycles -> head=(8,8), length=3, rd_idx 1 and 2 read (7,8) and (6,8), rd_idx 3 gives rd_valid=0.
- btnLeft while dir=RIGHT, then tick -> request ignored, head moves to (9,8); then btnUp and tick -> head (9,7).
- Food at (9,8) on the first tick -> ate pulses once, length=4, tail segment (6,8) kept.
- WRAP=1: drive head to x=15 moving right, tick -> headX=0; WRAP=0, same stimulus -> game_over=1, head unchanged, start returns to INIT.
- Grow to length 5, then steer Up, Left, Down -> self-hit and DEAD. Separately, a head stepping onto the current tail cell while not growing -> no death.
- Tick during SCAN -> tick_miss pulses once and step count unchanged; reset asserted mid-SCAN -> state INIT on the next edge, length=0, then 3.
